// File: rtl/add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencers.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_word.sv
// One-word adder/subtractor: s = a + (add_sub ? b : ~b) + cin, with carry out and carry into the MSB.
module add_word
  import add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             add_sub,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    b_eff = (add_sub == OP_ADD) ? b : ~b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    s     = sum[WIDTH-1:0];
    cout  = sum[WIDTH];
    // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum bit.
    c_msb = s[WIDTH-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
  end

endmodule

// File: rtl/add_seq.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit word per clock through add_word, LSW first.
//   state | meaning
//   IDLE  | waiting for an operand request, in_ready high
//   RUN   | processing word idx, carry chained in carry_q
//   DONE  | result held on out_* until out_ready
module add_seq
  import add_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NWORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NWORDS*WIDTH-1:0] in_a,
  input  logic [NWORDS*WIDTH-1:0] in_b,
  input  logic                    in_add_sub,
  input  logic                    in_carry,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NWORDS*WIDTH-1:0] out_result,
  output logic                    out_carry,
  output logic                    out_ovf,
  output logic                    busy
);

  localparam int IDXW = (clog2(NWORDS) < 1) ? 1 : clog2(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef logic [NWORDS-1:0][WIDTH-1:0] words_t;

  state_t          state_q, state_d;
  words_t          a_q, a_d;
  words_t          b_q, b_d;
  words_t          result_q, result_d;
  logic            op_q, op_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            out_carry_q, out_carry_d;
  logic            out_ovf_q, out_ovf_d;

  logic [WIDTH-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;

  add_word #(.WIDTH(WIDTH)) u_add_word (
    .a       (a_q[idx_q]),
    .b       (b_q[idx_q]),
    .cin     (carry_q),
    .add_sub (op_q),
    .s       (w_s),
    .cout    (w_cout),
    .c_msb   (w_cmsb)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    op_d        = op_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_add_sub;
          carry_d = in_carry;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q] = w_s;
        carry_d         = w_cout;
        idx_d           = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          out_carry_d = w_cout;
          out_ovf_d   = w_cmsb ^ w_cout;
          idx_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = result_q;
  assign out_carry  = out_carry_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: directed vectors, backpressure, reset abort and random back-to-back ops.
module tb_add_seq;

  localparam int WIDTH  = 8;
  localparam int NWORDS = 4;
  localparam int TW     = WIDTH * NWORDS;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_a;
  logic [TW-1:0] in_b;
  logic          in_add_sub;
  logic          in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_result;
  logic          out_carry;
  logic          out_ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;

  add_seq #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_add_sub (in_add_sub),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: whole-operand arithmetic, returns {ovf, carry, result}.
  function automatic logic [TW+1:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                          input logic op, input logic cin);
    logic [TW-1:0] bb;
    logic [TW:0]   full;
    logic          ovf;
    bb   = op ? b : ~b;
    full = {1'b0, a} + {1'b0, bb} + {{TW{1'b0}}, cin};
    ovf  = (a[TW-1] == bb[TW-1]) && (full[TW-1] != a[TW-1]);
    return {ovf, full[TW], full[TW-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    in_a       = $urandom;
    in_b       = $urandom;
    in_add_sub = 1'($urandom_range(0, 1));
    in_carry   = 1'($urandom_range(0, 1));
  endtask

  // Drives one op from IDLE, returns observed outputs and cycles from accept to out_valid (-1 on timeout).
  task automatic do_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic op,
                       input logic cin, output logic [TW-1:0] res, output logic c,
                       output logic v, output int lat);
    in_valid = 1'b1; in_a = a; in_b = b; in_add_sub = op; in_carry = cin;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    randomize_inputs();
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    res = out_result; c = out_carry; v = out_ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_add_sub = 1'b0; in_carry = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (out_result !== '0 || out_carry !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: result=%h carry=%b ovf=%b expected 0 0 0", out_result, out_carry, out_ovf);
    end
  endtask

  task automatic test_directed();
    logic [TW-1:0] va[6], vb[6], vr[6];
    logic          vop[6], vcin[6], vc[6], vv[6];
    logic [TW-1:0] res;
    logic          c, v;
    int            lat;
    va = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 32'h12345678};
    vb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h11111111};
    vop  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vcin = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vr = '{32'h00000100, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h23456789};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vop[i], vcin[i], res, c, v, lat);
      checks++;
      if (lat != NWORDS) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, NWORDS);
      end
      checks++;
      if (res !== vr[i] || c !== vc[i] || v !== vv[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h c=%b v=%b expected %h c=%b v=%b",
                 i, res, c, v, vr[i], vc[i], vv[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] a1, b1, a2, b2;
    logic          op1, cin1, op2, cin2;
    logic [TW+1:0] exp1, exp2;
    int            lat;
    a1 = $urandom; b1 = $urandom; op1 = 1'($urandom_range(0, 1)); cin1 = 1'($urandom_range(0, 1));
    a2 = $urandom; b2 = $urandom; op2 = 1'($urandom_range(0, 1)); cin2 = 1'($urandom_range(0, 1));
    exp1 = model(a1, b1, op1, cin1);
    exp2 = model(a2, b2, op2, cin2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = a1; in_b = b1; in_add_sub = op1; in_carry = cin1;
    tick();
    in_a = a2; in_b = b2; in_add_sub = op2; in_carry = cin2;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != NWORDS) begin
      errors++;
      $display("FAIL bp_latency: got %0d expected %0d", lat, NWORDS);
    end
    for (int n = 0; n < 10; n++) begin
      checks++;
      if ({out_ovf, out_carry, out_result} !== exp1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b c=%b r=%h valid=%b ready=%b expected v=%b c=%b r=%h valid=1 ready=0",
                 n, out_ovf, out_carry, out_result, out_valid, in_ready, exp1[TW+1], exp1[TW], exp1[TW-1:0]);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != NWORDS || {out_ovf, out_carry, out_result} !== exp2) begin
      errors++;
      $display("FAIL bp_next_op: lat=%0d got %h expected lat=%0d %h", lat,
               {out_ovf, out_carry, out_result}, NWORDS, exp2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [TW-1:0] res;
    logic          c, v;
    int            lat;
    bit            rose;
    in_valid = 1'b1;
    randomize_inputs();
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: busy=%b in_ready=%b expected 1 0", busy, in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_result !== '0 || out_carry !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: ready=%b valid=%b busy=%b r=%h c=%b v=%b expected 1 0 0 0 0 0",
               in_ready, out_valid, busy, out_result, out_carry, out_ovf);
    end
    rose = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (out_valid) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL abort_no_valid: out_valid rose=%b expected 0", rose);
    end
    do_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, res, c, v, lat);
    checks++;
    if (lat != NWORDS || res !== 32'h23456789 || c !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL abort_follow_op: lat=%0d r=%h c=%b v=%b expected %0d 23456789 0 0", lat, res, c, v, NWORDS);
    end
  endtask

  task automatic test_back_to_back();
    logic [TW+1:0] q[$];
    logic [TW+1:0] exp;
    int            got, cyc, last_acc, budget;
    bit            acc;
    got = 0; cyc = 0; last_acc = -1;
    budget = 1000 * (NWORDS + 2) + 100;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    randomize_inputs();
    while (got < 1000 && cyc < budget) begin
      acc = in_ready;
      if (acc) begin
        q.push_back(model(in_a, in_b, in_add_sub, in_carry));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != NWORDS + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected %0d", cyc - last_acc, NWORDS + 2);
          end
        end
        last_acc = cyc;
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected: result %h with no outstanding op expected none", out_result);
        end else begin
          exp = q.pop_front();
          if ({out_ovf, out_carry, out_result} !== exp) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got v=%b c=%b r=%h expected v=%b c=%b r=%h", got,
                     out_ovf, out_carry, out_result, exp[TW+1], exp[TW], exp[TW-1:0]);
          end
        end
        got++;
      end
      tick();
      cyc++;
      if (acc) randomize_inputs();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 1000) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d results expected 1000", got);
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
- Multi-precision add/subtract sequencer.
- Accepts NWORDS*WIDTH-bit operands over a valid/ready handshake and processes one WIDTH-bit word per clock through a single word adder, LSW first, chaining the carry in a register.
- Presents the full result, carry and signed overflow on an output valid/ready handshake.
- Sits between the operand source (register file or microsequencer) and the writeback path, wherever a wide add must reuse a narrow adder.

Parameters:
- WIDTH, 8, bits per word processed each cycle.
- NWORDS, 4, number of words per operand (>=1); total operand width is NWORDS*WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  NWORDS*WIDTH  operand A.
- in_b  in  NWORDS*WIDTH  operand B.
- in_add_sub  in  1  1 = A+B+cin; 0 = A+~B+cin (subtract, cin=1 means no incoming borrow).
- in_carry  in  1  carry into word 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  NWORDS*WIDTH  sum/difference.
- out_carry  out  1  carry out of the top word; for subtract, 1 = no borrow.
- out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: port rst, sampled on rising edge of clk.
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: in_ready=1 (combinational, IDLE), out_valid=0, busy=0, out_result=0, out_carry=0, out_ovf=0, word index=0, carry reg=0.
- IDLE: in_ready=1.
  - On in_valid&&in_ready, latch in_a, in_b, in_add_sub; carry reg<=in_carry; idx<=0; go to RUN.
  - in_valid with no accept is ignored.
- RUN: in_ready=0.
  - Each cycle: {c,s} = a[idx] + (op ? b[idx] : ~b[idx]) + carry, computed at WIDTH+1 bits.
  - result[idx]<=s; carry<=c; idx<=idx+1.
  - At idx==NWORDS-1: capture out_carry=c and out_ovf=(carry into bit WIDTH-1 of that word) XOR c, then go to DONE.
- DONE: out_valid=1.
  - out_result, out_carry and out_ovf stay stable while out_valid && !out_ready (backpressure of any length).
  - On out_ready, go to IDLE with out_valid=0 next cycle.
  - in_ready=0 in DONE; no bypass.
- Latency: out_valid rises exactly NWORDS cycles after the accepting edge.
- Throughput: one op per NWORDS+2 cycles minimum.
- NWORDS=1: RUN lasts one cycle.
- Input operands are not required to be held after acceptance; internal copies are used.
- Changes to in_* during RUN/DONE have no effect.
- rst asserted in any state, including mid-RUN or DONE with backpressure: the op is discarded, IDLE is entered next cycle, out_valid=0 and all outputs return to reset values. No partial result is ever presented.
- idx width is clog2(NWORDS), minimum 1; idx never wraps because RUN exits at NWORDS-1.
- Subtract convention: A-B is requested with in_add_sub=0, in_carry=1. A borrow chain passes through carry across calls.

Decomposition:
- Shared package add_pkg:
  - state enum (IDLE, RUN, DONE).
  - ADD/SUB opcode constants (OP_SUB=0, OP_ADD=1).
  - clog2 helper function.
- One combinational sub-module, add_word: inputs a, b, cin, add_sub; outputs s, cout, c_msb (carry into MSB). It is instantiated once and reusable by other sequencers.
- add_seq holds the FSM, operand/result registers and word muxing.

Test Plan (WIDTH=8, NWORDS=4):
- Add 0x000000FF + 0x00000001, cin=0 -> out_result=0x00000100, out_carry=0, out_ovf=0, out_valid 4 cycles after accept.
- Add 0xFFFFFFFF + 0x00000001, cin=0 -> out_result=0x00000000, out_carry=1, out_ovf=0; then 0x7FFFFFFF + 0x00000001 -> 0x80000000, carry=0, ovf=1.
- Sub 0x00000000 - 0x00000001 (add_sub=0, cin=1) -> 0xFFFFFFFF, out_carry=0 (borrow), ovf=0; then 0x80000000 - 1 -> 0x7FFFFFFF, carry=1, ovf=1.
- Hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> outputs stable, in_ready=0, no second accept; release -> IDLE, next op accepted.
- Assert rst at the second RUN cycle -> next cycle IDLE, in_ready=1, out_valid never rises for the aborted op; a following op 0x12345678+0x11111111 -> 0x23456789.
- Back-to-back requests with out_ready tied high -> accepts spaced NWORDS+2 cycles apart; scoreboard matches a reference model over 1000 random ops including random cin and add_sub.
